// File: rtl/mem_1r1w_ctrl.sv
// mem_1r1w_ctrl
// Presents a one-read/one-write port pair on top of a single-port SRAM.
// A read always owns the SRAM port in the cycle it is accepted. Writes that
// cannot reach the SRAM right away are posted into a small FIFO and drained
// in acceptance order whenever the port is free.
//
// Build option: MEM_1R1W_FWD_EN
//   defined   - reads merge bytes from matching queued writes, so a read never
//               waits for the queue to drain.
//   undefined - no forwarding state; a read whose address matches a queued
//               write is held off until that write has drained.
module mem_1r1w_ctrl #(
  parameter int DW    = 32,
  parameter int AW    = 10,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            reset,
  // Core-side write port
  input  logic            W0_en,
  input  logic [AW-1:0]   W0_addr,
  input  logic [DW-1:0]   W0_data,
  input  logic [DW/8-1:0] W0_mask,
  output logic            W0_ready,
  // Core-side read port
  input  logic            R0_en,
  input  logic [AW-1:0]   R0_addr,
  output logic            R0_ready,
  output logic            R0_valid,
  output logic [DW-1:0]   R0_data,
  // Single-port SRAM side
  output logic            ram_ce,
  output logic            ram_we,
  output logic [AW-1:0]   ram_addr,
  output logic [DW-1:0]   ram_wmask,
  output logic [DW-1:0]   ram_din,
  input  logic [DW-1:0]   ram_dout
);

  localparam int NB = DW / 8;
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  // Write queue storage and bookkeeping
  logic [AW-1:0] r_q_addr [DEPTH];
  logic [DW-1:0] r_q_data [DEPTH];
  logic [NB-1:0] r_q_mask [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          r_rvalid;

  logic w_full;
  logic w_empty;
  logic w_rd_acc;
  logic w_wr_acc;
  logic w_enq;
  logic w_deq;

  // Advance a queue index by 'off' slots, wrapping at DEPTH.
  function automatic logic [PW-1:0] f_wrap(input logic [PW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= DEPTH) begin
      s = s - DEPTH;
    end else begin
      s = s;
    end
    return PW'(s);
  endfunction

  // Expand per-byte enables into a per-bit mask.
  function automatic logic [DW-1:0] f_expand(input logic [NB-1:0] m);
    logic [DW-1:0] x;
    x = '0;
    for (int b = 0; b < NB; b++) begin
      x[b*8 +: 8] = {8{m[b]}};
    end
    return x;
  endfunction

  assign w_full   = (r_count == CW'(DEPTH));
  assign w_empty  = (r_count == CW'(0));
  assign W0_ready = !w_full;

`ifdef MEM_1R1W_FWD_EN
  assign R0_ready = !w_full;
`else
  logic w_hit;

  // Flag any occupied queue slot holding the address being read.
  always_comb begin
    w_hit = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      w_hit = w_hit | ((CW'(k) < r_count) && (r_q_addr[f_wrap(r_rptr, k)] == R0_addr));
    end
  end

  // A read matching a posted write waits until that write is in the SRAM.
  assign R0_ready = !w_full && !w_hit;
`endif

  // Nothing is accepted while reset is held, so the SRAM stays quiet.
  assign w_rd_acc = R0_en && R0_ready && !reset;
  assign w_wr_acc = W0_en && W0_ready && !reset;

  // Arbitrate the single SRAM port: read, then queue drain, then bypass write.
  always_comb begin
    ram_ce    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wmask = '0;
    ram_din   = '0;
    w_enq     = 1'b0;
    w_deq     = 1'b0;
    if (w_rd_acc) begin
      // Read owns the port; a concurrent write is posted behind older ones.
      ram_ce   = 1'b1;
      ram_addr = R0_addr;
      w_enq    = w_wr_acc;
    end else if (!w_empty) begin
      // Drain the oldest posted write. When the queue is full a pending read
      // lands here too, which is what frees a slot for it next cycle.
      ram_ce    = 1'b1;
      ram_we    = 1'b1;
      ram_addr  = r_q_addr[r_rptr];
      ram_wmask = f_expand(r_q_mask[r_rptr]);
      ram_din   = r_q_data[r_rptr];
      w_deq     = 1'b1;
      w_enq     = w_wr_acc;
    end else if (w_wr_acc) begin
      // Empty queue and a free port: the write goes straight to the SRAM.
      ram_ce    = 1'b1;
      ram_we    = 1'b1;
      ram_addr  = W0_addr;
      ram_wmask = f_expand(W0_mask);
      ram_din   = W0_data;
    end else begin
      ram_ce = 1'b0;
    end
  end

  // Queue pointers and occupancy; reset throws away any posted writes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_enq) begin
        r_wptr <= f_wrap(r_wptr, 1);
      end else begin
        r_wptr <= r_wptr;
      end
      if (w_deq) begin
        r_rptr <= f_wrap(r_rptr, 1);
      end else begin
        r_rptr <= r_rptr;
      end
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Queue payload, written at the tail when a write is posted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_q_addr[i] <= '0;
        r_q_data[i] <= '0;
        r_q_mask[i] <= '0;
      end
    end else if (w_enq) begin
      r_q_addr[r_wptr] <= W0_addr;
      r_q_data[r_wptr] <= W0_data;
      r_q_mask[r_wptr] <= W0_mask;
    end
  end

  // Read data is valid exactly one cycle after the read is accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rvalid <= 1'b0;
    end else begin
      r_rvalid <= w_rd_acc;
    end
  end

  assign R0_valid = r_rvalid;

`ifdef MEM_1R1W_FWD_EN
  logic [NB-1:0] w_fwd_mask;
  logic [DW-1:0] w_fwd_data;
  logic [NB-1:0] r_fwd_mask;
  logic [DW-1:0] r_fwd_data;

  // Merge matching posted writes oldest to newest so younger bytes win.
  always_comb begin
    logic [PW-1:0] v_slot;
    logic          v_hit;
    logic          v_take;
    w_fwd_mask = '0;
    w_fwd_data = '0;
    v_slot     = '0;
    v_hit      = 1'b0;
    v_take     = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      v_slot = f_wrap(r_rptr, k);
      v_hit  = (CW'(k) < r_count) && (r_q_addr[v_slot] == R0_addr);
      for (int b = 0; b < NB; b++) begin
        v_take                = v_hit && r_q_mask[v_slot][b];
        w_fwd_mask[b]         = w_fwd_mask[b] | v_take;
        w_fwd_data[b*8 +: 8]  = v_take ? r_q_data[v_slot][b*8 +: 8] : w_fwd_data[b*8 +: 8];
      end
    end
  end

  // Capture the merged bytes alongside the SRAM read they will overlay.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fwd_mask <= '0;
      r_fwd_data <= '0;
    end else if (w_rd_acc) begin
      r_fwd_mask <= w_fwd_mask;
      r_fwd_data <= w_fwd_data;
    end
  end

  // Overlay forwarded bytes on the SRAM output.
  always_comb begin
    R0_data = ram_dout;
    for (int b = 0; b < NB; b++) begin
      if (r_fwd_mask[b]) begin
        R0_data[b*8 +: 8] = r_fwd_data[b*8 +: 8];
      end else begin
        R0_data[b*8 +: 8] = ram_dout[b*8 +: 8];
      end
    end
  end
`else
  assign R0_data = ram_dout;
`endif

endmodule

// File: tb/tb_mem_1r1w_ctrl.sv
`timescale 1ns/1ps
module tb_mem_1r1w_ctrl;
  localparam int DW    = 32;
  localparam int AW    = 10;
  localparam int DEPTH = 2;
  localparam int NB    = DW / 8;
  localparam int MSZ   = 1 << AW;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [NB-1:0] m;
  } wr_t;

  logic          clk;
  logic          reset;
  logic          W0_en;
  logic [AW-1:0] W0_addr;
  logic [DW-1:0] W0_data;
  logic [NB-1:0] W0_mask;
  logic          W0_ready;
  logic          R0_en;
  logic [AW-1:0] R0_addr;
  logic          R0_ready;
  logic          R0_valid;
  logic [DW-1:0] R0_data;
  logic          ram_ce;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wmask;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;

  mem_1r1w_ctrl #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .W0_en(W0_en), .W0_addr(W0_addr), .W0_data(W0_data), .W0_mask(W0_mask), .W0_ready(W0_ready),
    .R0_en(R0_en), .R0_addr(R0_addr), .R0_ready(R0_ready), .R0_valid(R0_valid), .R0_data(R0_data),
    .ram_ce(ram_ce), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wmask(ram_wmask),
    .ram_din(ram_din), .ram_dout(ram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port SRAM: bit-masked write, registered read data.
  logic [DW-1:0] sram_mem [MSZ];
  logic          sram_clear;
  always @(posedge clk) begin
    if (sram_clear) begin
      for (int i = 0; i < MSZ; i++) sram_mem[i] <= '0;
      ram_dout <= '0;
    end else if (ram_ce) begin
      if (ram_we) sram_mem[ram_addr] <= (sram_mem[ram_addr] & ~ram_wmask) | (ram_din & ram_wmask);
      else        ram_dout <= sram_mem[ram_addr];
    end
  end

  // Reference model: architectural memory (all accepted writes), the SRAM
  // contents it expects, and the list of accepted writes not yet in the SRAM.
  logic [DW-1:0] model_mem [MSZ];
  logic [DW-1:0] golden    [MSZ];
  wr_t           q [$];
  logic          pend_valid;
  logic [DW-1:0] pend_data;

  int            n_checks;
  int            n_fail;
  logic          obs_wr, obs_rr, obs_we;
  logic          last_racc, last_wacc;
  logic [DW-1:0] last_vdata;
  int            n_stall;

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] d,
                                          input logic [NB-1:0] m);
    logic [DW-1:0] r;
    r = old;
    for (int b = 0; b < NB; b++) if (m[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  function automatic logic [DW-1:0] expand(input logic [NB-1:0] m);
    logic [DW-1:0] r;
    for (int b = 0; b < NB; b++) r[b*8 +: 8] = {8{m[b]}};
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive, check at the falling edge, advance the model.
  task automatic cycle(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic [NB-1:0] wm, input logic re, input logic [AW-1:0] ra);
    logic full, hit, exp_wr, exp_rr, racc, wacc, e_ce, e_we;
    logic [AW-1:0] e_addr;
    wr_t nw, e_ent;
    W0_en = we; W0_addr = wa; W0_data = wd; W0_mask = wm;
    R0_en = re; R0_addr = ra;
    @(negedge clk);
    full = (q.size() == DEPTH);
    hit  = 1'b0;
    foreach (q[i]) if (q[i].a == ra) hit = 1'b1;
    exp_wr = !full;
`ifdef MEM_1R1W_FWD_EN
    exp_rr = !full;
`else
    exp_rr = !full && !hit;
`endif
    racc = re && exp_rr;
    wacc = we && exp_wr;
    nw = '{a: wa, d: wd, m: wm};
    e_ce = 1'b0; e_we = 1'b0; e_addr = '0; e_ent = nw;
    if (racc) begin
      e_ce = 1'b1; e_addr = ra;
    end else if (q.size() > 0) begin
      e_ce = 1'b1; e_we = 1'b1; e_ent = q[0]; e_addr = q[0].a;
    end else if (wacc) begin
      e_ce = 1'b1; e_we = 1'b1; e_addr = wa;
    end
    obs_wr = W0_ready; obs_rr = R0_ready; obs_we = ram_we;
    chk("w0_ready", W0_ready, exp_wr);
    chk("r0_ready", R0_ready, exp_rr);
    chk("r0_valid", R0_valid, pend_valid);
    if (pend_valid) begin
      chk("r0_data", R0_data, pend_data);
      last_vdata = R0_data;
    end
    chk("ram_ce", ram_ce, e_ce);
    if (e_ce) begin
      chk("ram_we", ram_we, e_we);
      chk("ram_addr", ram_addr, e_addr);
    end
    if (e_we) begin
      chk("ram_wmask", ram_wmask, expand(e_ent.m));
      chk("ram_din", ram_din, e_ent.d);
    end
    pend_valid = racc;
    if (racc) pend_data = model_mem[ra];
    if (wacc) begin
      model_mem[wa] = merge(model_mem[wa], wd, wm);
      q.push_back(nw);
    end
    if (e_we) begin
      golden[e_ent.a] = merge(golden[e_ent.a], e_ent.d, e_ent.m);
      void'(q.pop_front());
    end
    last_racc = racc;
    last_wacc = wacc;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, '0, 1'b0, '0);
  endtask

  // Hold a read request until it is accepted, within a bounded number of cycles.
  task automatic read_until(input logic [AW-1:0] ra);
    n_stall = 0;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, '0, '0, '0, 1'b1, ra);
      if (last_racc) break;
      n_stall++;
    end
    chk("read_accept_timeout", last_racc, 1'b1);
  endtask

  task automatic do_midreset();
    W0_en = 1'b0; R0_en = 1'b0;
    reset = 1'b1;
    #1;
    chk("midrst_r0_valid", R0_valid, 1'b0);
    chk("midrst_w0_ready", W0_ready, 1'b1);
    chk("midrst_ram_ce", ram_ce, 1'b0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    q.delete();
    for (int i = 0; i < MSZ; i++) model_mem[i] = golden[i];
    pend_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic          cw_en, cr_en;
    logic [AW-1:0] cw_a, cr_a;
    logic [DW-1:0] cw_d;
    logic [NB-1:0] cw_m;
    n_checks = 0; n_fail = 0;
    pend_valid = 1'b0; pend_data = '0;
    last_racc = 1'b0; last_wacc = 1'b0; last_vdata = '0;
    for (int i = 0; i < MSZ; i++) begin model_mem[i] = '0; golden[i] = '0; end
    sram_clear = 1'b1;
    reset = 1'b1;
    W0_en = 1'b0; W0_addr = '0; W0_data = '0; W0_mask = '0;
    R0_en = 1'b0; R0_addr = '0;
    @(posedge clk); #1;
    sram_clear = 1'b0;
    chk("rst_r0_valid", R0_valid, 1'b0);
    chk("rst_ram_ce", ram_ce, 1'b0);
    chk("rst_ram_we", ram_we, 1'b0);
    chk("rst_w0_ready", W0_ready, 1'b1);
    chk("rst_r0_ready", R0_ready, 1'b1);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("post_rst_ram_ce", ram_ce, 1'b0);
    chk("post_rst_w0_ready", W0_ready, 1'b1);
    chk("post_rst_r0_ready", R0_ready, 1'b1);

    // Same-cycle read and write to address 5.
    cycle(1'b1, 10'd5, 32'h11111111, 4'hF, 1'b0, '0);
    cycle(1'b1, 10'd5, 32'hAAAAAAAA, 4'hF, 1'b1, 10'd5);
    read_until(10'd5);
    chk("rw_same_cycle_old", last_vdata, 32'h11111111);
`ifdef MEM_1R1W_FWD_EN
    chk("fwd_no_stall", n_stall, 0);
`else
    chk("hit_stall_seen", (n_stall >= 1), 1'b1);
`endif
    idle(1);
    chk("rw_next_read_new", last_vdata, 32'hAAAAAAAA);
    idle(3);

    // Partial-mask write posted during a read stream, then read back.
    cycle(1'b1, 10'd7, 32'h00000000, 4'hF, 1'b0, '0);
    cycle(1'b0, '0, '0, '0, 1'b1, 10'd0);
    cycle(1'b1, 10'd7, 32'h12345678, 4'h5, 1'b1, 10'd0);
    read_until(10'd7);
`ifdef MEM_1R1W_FWD_EN
    chk("fwd_before_drain", sram_mem[7], 32'h00000000);
`endif
    idle(1);
    chk("partial_mask_read", last_vdata, 32'h00340078);
    idle(3);

    // Fill the queue with back-to-back reads, then watch it release.
    cycle(1'b1, 10'd20, 32'h01020304, 4'hF, 1'b1, 10'd0);
    cycle(1'b1, 10'd21, 32'h05060708, 4'hF, 1'b1, 10'd1);
    cycle(1'b0, '0, '0, '0, 1'b1, 10'd2);
    chk("full_w0_ready", obs_wr, 1'b0);
    chk("full_r0_ready", obs_rr, 1'b0);
    chk("full_drain_we", obs_we, 1'b1);
    cycle(1'b0, '0, '0, '0, 1'b1, 10'd2);
    chk("after_drain_w0_ready", obs_wr, 1'b1);
    chk("after_drain_r0_ready", obs_rr, 1'b1);
    idle(3);

    // Two writes to one address drain in order.
    cycle(1'b1, 10'd30, 32'hC0DE0001, 4'hF, 1'b1, 10'd0);
    cycle(1'b1, 10'd30, 32'hC0DE0002, 4'hF, 1'b1, 10'd0);
    idle(4);
    chk("drain_order_final", sram_mem[30], 32'hC0DE0002);

    // Reset with two posted writes.
    cycle(1'b1, 10'd40, 32'hDEADBEEF, 4'hF, 1'b1, 10'd0);
    cycle(1'b1, 10'd41, 32'hCAFEF00D, 4'hF, 1'b1, 10'd1);
    do_midreset();
    idle(4);
    chk("discarded_40", sram_mem[40], 32'h00000000);
    chk("discarded_41", sram_mem[41], 32'h00000000);

    // Randomized traffic on a small address window; unaccepted requests are held.
    cw_en = 1'b0; cr_en = 1'b0; cw_a = '0; cr_a = '0; cw_d = '0; cw_m = '0;
    for (int n = 0; n < 400; n++) begin
      if (!cw_en || last_wacc) begin
        cw_en = 1'($urandom_range(0, 1));
        cw_a  = AW'($urandom_range(0, 7));
        cw_d  = $urandom;
        cw_m  = NB'($urandom_range(0, 15));
      end
      if (!cr_en || last_racc) begin
        cr_en = 1'($urandom_range(0, 1));
        cr_a  = AW'($urandom_range(0, 7));
      end
      cycle(cw_en, cw_a, cw_d, cw_m, cr_en, cr_a);
    end
    idle(6);
    for (int i = 0; i < 64; i++) chk("final_mem", sram_mem[i], model_mem[i]);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
